// File: rtl/peripheral_wb_pkg.sv
// Shared definitions for the WishBone UART: line-control bit positions,
// transmitter state encoding and stop-bit length helper.
package peripheral_wb_pkg;

  localparam int unsigned UART_LC_WL_LO = 0;
  localparam int unsigned UART_LC_WL_HI = 1;
  localparam int unsigned UART_LC_SB    = 2;
  localparam int unsigned UART_LC_PE    = 3;
  localparam int unsigned UART_LC_EP    = 4;
  localparam int unsigned UART_LC_SP    = 5;
  localparam int unsigned UART_LC_BC    = 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } uart_tx_state_t;

  // Stop length in enable ticks: 1, 1.5 (5-bit words) or 2 bit periods.
  function automatic int unsigned stop_ticks(input logic sb, input logic [1:0] wl,
                                             input int unsigned os);
    if (!sb)
      return os;
    else if (wl == 2'b00)
      return (3 * os) / 2;
    else
      return 2 * os;
  endfunction

endpackage

// File: rtl/peripheral_uart_tfifo_param_wb.sv
// Parametrised transmit FIFO with occupancy count, sticky overrun flag,
// synchronous flush and status clear.
module peripheral_uart_tfifo_param_wb #(
  parameter int unsigned FIFO_WIDTH     = 8,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned FIFO_POINTER_W = $clog2(FIFO_DEPTH),
  parameter int unsigned FIFO_COUNTER_W = FIFO_POINTER_W + 1
) (
  input  logic                      clk,
  input  logic                      wb_rst_i,
  input  logic [FIFO_WIDTH-1:0]     data_in,
  output logic [FIFO_WIDTH-1:0]     data_out,
  input  logic                      push,
  input  logic                      pop,
  output logic                      overrun,
  output logic [FIFO_COUNTER_W-1:0] count,
  input  logic                      fifo_reset,
  input  logic                      reset_status
);

  logic [FIFO_WIDTH-1:0]     mem [FIFO_DEPTH];
  logic [FIFO_POINTER_W-1:0] top, bottom;
  logic                      full, empty, do_push, do_pop;

  assign full     = (count == FIFO_COUNTER_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A push at full is accepted only when a pop frees the slot in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign data_out = mem[bottom];

  always_ff @(posedge clk) begin
    if (do_push && !fifo_reset)
      mem[top] <= data_in;
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      top    <= '0;
      bottom <= '0;
      count  <= '0;
    end else if (fifo_reset) begin
      top    <= '0;
      bottom <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        top <= top + FIFO_POINTER_W'(1);
      if (do_pop)
        bottom <= bottom + FIFO_POINTER_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + FIFO_COUNTER_W'(1);
        2'b01:   count <= count - FIFO_COUNTER_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i)
      overrun <= 1'b0;
    else if (push && full && !do_pop && !fifo_reset)
      overrun <= 1'b1;
    else if (reset_status)
      overrun <= 1'b0;
  end

endmodule

// File: rtl/peripheral_uart_transmitter_param_wb.sv
// UART transmit path: TX FIFO plus oversampled serialiser with 16550 line
// control and optional CTS gating of frame start.
module peripheral_uart_transmitter_param_wb
  import peripheral_wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned FIFO_POINTER_W = $clog2(FIFO_DEPTH),
  parameter int unsigned FIFO_COUNTER_W = FIFO_POINTER_W + 1,
  parameter int unsigned OVERSAMPLE     = 16,
  parameter int unsigned CTS_EN         = 1
) (
  input  logic                      clk,
  input  logic                      wb_rst_i,
  input  logic [7:0]                lcr,
  input  logic                      tf_push,
  input  logic [7:0]                wb_dat_i,
  input  logic                      enable,
  input  logic                      tx_reset,
  input  logic                      lsr_mask,
  input  logic                      cts_n,
  output logic                      stx_pad_o,
  output logic [2:0]                tstate,
  output logic [FIFO_COUNTER_W-1:0] tf_count,
  output logic                      tf_overrun,
  output logic                      tx_idle
);

  localparam int unsigned CNT_W = $clog2(2 * OVERSAMPLE + 1);

  uart_tx_state_t state_q, state_d;
  logic [CNT_W-1:0] tick_q, tick_d, os_last, stop_last;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d, fifo_head, act_mask;
  logic [1:0]       wl_q, wl_d;
  logic             line_q, line_d, par_q, par_d;
  logic             tf_pop, cts_ok, parity_bit;
  logic             unused_lcr;

  assign unused_lcr = lcr[7];

  peripheral_uart_tfifo_param_wb #(
    .FIFO_WIDTH    (8),
    .FIFO_DEPTH    (FIFO_DEPTH),
    .FIFO_POINTER_W(FIFO_POINTER_W),
    .FIFO_COUNTER_W(FIFO_COUNTER_W)
  ) u_tfifo (
    .clk         (clk),
    .wb_rst_i    (wb_rst_i),
    .data_in     (wb_dat_i),
    .data_out    (fifo_head),
    .push        (tf_push),
    .pop         (tf_pop),
    .overrun     (tf_overrun),
    .count       (tf_count),
    .fifo_reset  (tx_reset),
    .reset_status(lsr_mask)
  );

  assign cts_ok    = (CTS_EN == 0) || !cts_n;
  assign act_mask  = 8'hFF >> (2'd3 - lcr[UART_LC_WL_HI:UART_LC_WL_LO]);
  assign os_last   = CNT_W'(OVERSAMPLE - 1);
  assign stop_last = CNT_W'(stop_ticks(lcr[UART_LC_SB], wl_q, OVERSAMPLE) - 1);
  assign parity_bit = lcr[UART_LC_SP] ? ~lcr[UART_LC_EP]
                                      : (lcr[UART_LC_EP] ? par_q : ~par_q);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    line_d  = line_q;
    par_d   = par_q;
    wl_d    = wl_q;
    tf_pop  = 1'b0;
    if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (tf_count != '0 && cts_ok)
            state_d = S_POP;
        end
        S_POP: begin
          tf_pop  = 1'b1;
          shift_d = fifo_head;
          bit_d   = {1'b1, lcr[UART_LC_WL_HI:UART_LC_WL_LO]};
          par_d   = ^(fifo_head & act_mask);
          wl_d    = lcr[UART_LC_WL_HI:UART_LC_WL_LO];
          tick_d  = '0;
          line_d  = 1'b0;
          state_d = S_START;
        end
        S_START: begin
          if (tick_q == os_last) begin
            tick_d  = '0;
            line_d  = shift_q[0];
            shift_d = shift_q >> 1;
            state_d = S_DATA;
          end else begin
            tick_d = tick_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          // The next level is loaded on the boundary tick so no bit period is stretched.
          if (tick_q == os_last) begin
            tick_d = '0;
            if (bit_q == 3'd0) begin
              if (lcr[UART_LC_PE]) begin
                line_d  = parity_bit;
                state_d = S_PARITY;
              end else begin
                line_d  = 1'b1;
                state_d = S_STOP;
              end
            end else begin
              bit_d   = bit_q - 3'd1;
              line_d  = shift_q[0];
              shift_d = shift_q >> 1;
            end
          end else begin
            tick_d = tick_q + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (tick_q == os_last) begin
            tick_d  = '0;
            line_d  = 1'b1;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (tick_q == stop_last) begin
            tick_d  = '0;
            state_d = S_IDLE;
          end else begin
            tick_d = tick_q + CNT_W'(1);
          end
        end
        default: begin
          tick_d  = '0;
          line_d  = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      line_q  <= 1'b1;
      par_q   <= 1'b0;
      wl_q    <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      line_q  <= line_d;
      par_q   <= par_d;
      wl_q    <= wl_d;
    end
  end

  assign tstate    = state_q;
  assign stx_pad_o = lcr[UART_LC_BC] ? 1'b0 : line_q;
  assign tx_idle   = (state_q == S_IDLE) && (tf_count == '0);

endmodule

// File: tb/tb_peripheral_uart_transmitter_param_wb.sv
// Self-checking bench: a tick-level frame model predicts the pin, FIFO count,
// overrun and idle status every cycle; directed tests pin frame contents.
module tb_peripheral_uart_transmitter_param_wb;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned OS    = 16;

  logic       clk = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic [7:0] lcr = 8'h03;
  logic       tf_push = 1'b0;
  logic [7:0] wb_dat_i = '0;
  logic       enable = 1'b0;
  logic       tx_reset = 1'b0;
  logic       lsr_mask = 1'b0;
  logic       cts_n = 1'b0;
  logic       stx_pad_o;
  logic [2:0] tstate;
  logic [4:0] tf_count;
  logic       tf_overrun;
  logic       tx_idle;

  bit en_run = 1'b0;
  int errors = 0;
  int checks = 0;

  peripheral_uart_transmitter_param_wb #(
    .FIFO_DEPTH(DEPTH),
    .OVERSAMPLE(OS),
    .CTS_EN    (1)
  ) dut (
    .clk       (clk),
    .wb_rst_i  (wb_rst_i),
    .lcr       (lcr),
    .tf_push   (tf_push),
    .wb_dat_i  (wb_dat_i),
    .enable    (enable),
    .tx_reset  (tx_reset),
    .lsr_mask  (lsr_mask),
    .cts_n     (cts_n),
    .stx_pad_o (stx_pad_o),
    .tstate    (tstate),
    .tf_count  (tf_count),
    .tf_overrun(tf_overrun),
    .tx_idle   (tx_idle)
  );

  always #5 clk = ~clk;

  // Oversample tick every second clock while running.
  always @(negedge clk) enable = en_run ? ~enable : 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out, got no event, expected one (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mf[$];
  bit         lq[$];
  bit         m_line = 1'b1;
  bit         m_ovr = 1'b0;
  bit         pend_pop = 1'b0;
  bit         m_popnow, m_setovr;

  // Pin levels after each tick following the frame-start decision.
  function automatic void build_frame(input logic [7:0] d, input logic [7:0] l);
    int unsigned wl;
    int unsigned nstop;
    bit x;
    bit pb;
    wl = int'(l[1:0]) + 5;
    x  = 1'b0;
    for (int unsigned i = 0; i < OS; i++) lq.push_back(1'b0);
    for (int unsigned b = 0; b < wl; b++) begin
      x = x ^ d[b];
      for (int unsigned i = 0; i < OS; i++) lq.push_back(d[b]);
    end
    if (l[3]) begin
      pb = l[5] ? !l[4] : (l[4] ? x : !x);
      for (int unsigned i = 0; i < OS; i++) lq.push_back(pb);
    end
    nstop = !l[2] ? OS : ((wl == 5) ? (OS * 3) / 2 : 2 * OS);
    for (int unsigned i = 0; i <= nstop; i++) lq.push_back(1'b1);
  endfunction

  always @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      mf.delete();
      lq.delete();
      m_line   = 1'b1;
      m_ovr    = 1'b0;
      pend_pop = 1'b0;
    end else begin
      m_popnow = 1'b0;
      m_setovr = 1'b0;
      if (enable) begin
        if (pend_pop) begin
          m_popnow = 1'b1;
          pend_pop = 1'b0;
        end
        if (lq.size() == 0) begin
          if (mf.size() != 0 && !cts_n) begin
            build_frame(mf[0], lcr);
            m_line   = 1'b1;
            pend_pop = 1'b1;
          end
        end else begin
          m_line = lq.pop_front();
        end
      end
      if (m_popnow && mf.size() != 0) void'(mf.pop_front());
      if (tx_reset)
        mf.delete();
      else if (tf_push) begin
        if (mf.size() < DEPTH) mf.push_back(wb_dat_i);
        else m_setovr = 1'b1;
      end
      if (m_setovr) m_ovr = 1'b1;
      else if (lsr_mask) m_ovr = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("stx_pad_o", stx_pad_o, lcr[6] ? 1'b0 : m_line);
    chk("tx_idle", tx_idle, (lq.size() == 0) && (mf.size() == 0));
    chk("tf_count", tf_count, mf.size());
    chk("tf_overrun", tf_overrun, m_ovr);
    chk("tstate_is_idle", tstate == 3'd0, lq.size() == 0);
  end

  // ---------------- directed stimulus ----------------
  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic tick_wait();
    int g = 0;
    do begin
      @(posedge clk);
      g++;
    end while (!enable && g < 8);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    at_neg();
    wb_dat_i = d;
    tf_push  = 1'b1;
    at_neg();
    tf_push  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while (tstate !== 3'd0 && g < 4000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 4000) timeout_fail(name);
  endtask

  // Sample mid-bit levels of one frame and count ticks from start edge to IDLE.
  task automatic capture(input string name, input int unsigned nsamp,
                         output logic [15:0] s, output int unsigned total);
    int unsigned n = 0;
    int unsigned g = 0;
    s = '0;
    total = 0;
    while (stx_pad_o !== 1'b0 && g < 4000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 4000) begin
      timeout_fail(name);
      return;
    end
    while (n < 1000) begin
      tick_wait();
      n++;
      if (n >= 8 && (n - 8) % 16 == 0 && (n - 8) / 16 < nsamp)
        s[(n - 8) / 16] = stx_pad_o;
      if (tstate == 3'd0) break;
    end
    if (n >= 1000) timeout_fail(name);
    total = n;
  endtask

  logic [15:0] samp;
  int unsigned tot;
  int unsigned k;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_stx", stx_pad_o, 1'b1);
    chk("reset_idle", tx_idle, 1'b1);
    chk("reset_count", tf_count, 5'd0);
    chk("reset_state", tstate, 3'd0);
    chk("reset_ovr", tf_overrun, 1'b0);
    wb_rst_i = 1'b0;
    en_run = 1'b1;

    // 8N1, 0x55
    lcr = 8'h03;
    push(8'h55);
    capture("frame_8n1", 10, samp, tot);
    chk("8n1_bits", samp, 16'h02AA);
    chk("8n1_ticks", tot, 160);
    at_neg();
    chk("8n1_idle_after", tx_idle, 1'b1);

    // 5-bit, 1.5 stop bits
    lcr = 8'h04;
    push(8'h1F);
    capture("frame_5b", 7, samp, tot);
    chk("5b_bits", samp, 16'h007E);
    chk("5b_ticks", tot, 120);

    // 7-bit parity variants of 0x41
    lcr = 8'h1A;
    push(8'h41);
    capture("frame_even", 10, samp, tot);
    chk("even_bits", samp, 16'h0282);
    chk("even_ticks", tot, 160);
    lcr = 8'h0A;
    push(8'h41);
    capture("frame_odd", 10, samp, tot);
    chk("odd_bits", samp, 16'h0382);
    lcr = 8'h3A;
    push(8'h41);
    capture("frame_stick", 10, samp, tot);
    chk("stick_parity", samp[8], 1'b0);

    // Break control forces the pin low
    at_neg();
    lcr = 8'h43;
    at_neg();
    chk("break_low", stx_pad_o, 1'b0);
    lcr = 8'h03;

    // CTS gating
    at_neg();
    cts_n = 1'b1;
    push(8'hA5);
    repeat (40) tick_wait();
    chk("cts_held_line", stx_pad_o, 1'b1);
    chk("cts_held_count", tf_count, 5'd1);
    at_neg();
    cts_n = 1'b0;
    k = 0;
    do begin
      tick_wait();
      k++;
    end while (stx_pad_o !== 1'b0 && k < 10);
    chk("cts_start_latency", k, 2);
    push(8'h3C);
    repeat (60) tick_wait();
    at_neg();
    cts_n = 1'b1;
    wait_idle("cts_frame_done");
    repeat (40) tick_wait();
    chk("cts_second_held", stx_pad_o, 1'b1);
    chk("cts_second_count", tf_count, 5'd1);
    at_neg();
    cts_n = 1'b0;
    capture("frame_cts2", 10, samp, tot);
    chk("cts2_bits", samp, 16'h0278);

    // FIFO overflow, status clear, push+pop at full, flush
    en_run = 1'b0;
    repeat (3) at_neg();
    for (int i = 0; i < 17; i++) push(8'(i + 16));
    chk("full_count", tf_count, 5'd16);
    chk("overrun_set", tf_overrun, 1'b1);
    at_neg();
    lsr_mask = 1'b1;
    at_neg();
    lsr_mask = 1'b0;
    chk("overrun_clr", tf_overrun, 1'b0);
    en_run = 1'b1;
    at_neg();
    tf_push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wb_dat_i = 8'(8'hC0 + i);
      at_neg();
    end
    tf_push = 1'b0;
    chk("full_pushpop_count", tf_count, 5'd16);
    repeat (10) tick_wait();
    at_neg();
    tx_reset = 1'b1;
    tf_push  = 1'b1;
    wb_dat_i = 8'h99;
    at_neg();
    tx_reset = 1'b0;
    tf_push  = 1'b0;
    chk("flush_count", tf_count, 5'd0);
    wait_idle("flush_frame_done");
    at_neg();
    lsr_mask = 1'b1;
    at_neg();
    lsr_mask = 1'b0;

    // Asynchronous reset mid-DATA
    lcr = 8'h03;
    push(8'h55);
    push(8'h0F);
    k = 0;
    while (stx_pad_o !== 1'b0 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 4000) timeout_fail("rst_frame_start");
    repeat (40) tick_wait();
    @(negedge clk);
    #2;
    wb_rst_i = 1'b1;
    #1;
    chk("rst_mid_stx", stx_pad_o, 1'b1);
    chk("rst_mid_state", tstate, 3'd0);
    chk("rst_mid_count", tf_count, 5'd0);
    @(negedge clk);
    #2;
    wb_rst_i = 1'b0;
    push(8'h55);
    capture("frame_after_rst", 10, samp, tot);
    chk("after_rst_bits", samp, 16'h02AA);
    chk("after_rst_ticks", tot, 160);

    repeat (4) at_neg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no completion, expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
